// File: rtl/shenjing_instr_loader.sv
// shenjing_instr_loader: loads per-tile instruction memories of an X-by-Y NPU
// tile array from a valid/ready command stream, then steps every tile through
// its loaded program in lock-step on run_req.
module shenjing_instr_loader #(
  parameter  int X        = 4,
  parameter  int Y        = 3,
  parameter  int ADDR_W   = 6,
  parameter  int INSTR_W  = 20,
  parameter  int STEP_CYC = 4,
  localparam int ROW_W    = (X > 1) ? $clog2(X) : 1,
  localparam int COL_W    = (Y > 1) ? $clog2(Y) : 1
) (
  input  logic                                   clk_in,
  input  logic                                   rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [ROW_W-1:0]                       cmd_row,
  input  logic [COL_W-1:0]                       cmd_col,
  input  logic [INSTR_W-1:0]                     cmd_instr,
  input  logic                                   clear_req,
  input  logic                                   run_req,
  output logic                                   busy,
  output logic                                   done,
  output logic [1:0]                             err,
  output logic [X-1:0][Y-1:0]                    start_instr_b,
  output logic [X-1:0][Y-1:0]                    read_or_write,
  output logic [X-1:0][Y-1:0][ADDR_W-1:0]        addr_count,
  output logic [X-1:0][Y-1:0][INSTR_W-1:0]       instr_in
);

  localparam int PH_W  = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int ROW_N = 1 << ROW_W;
  localparam int COL_N = 1 << COL_W;
  localparam logic [ADDR_W:0]  DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(STEP_CYC - 1);
  // Coordinate validity as lookup masks, so unreachable codes simply read 0.
  localparam logic [ROW_N-1:0] ROW_MASK = ROW_N'((64'd1 << X) - 64'd1);
  localparam logic [COL_N-1:0] COL_MASK = COL_N'((64'd1 << Y) - 64'd1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state;
  logic [X-1:0][Y-1:0][ADDR_W:0] cnt;
  logic [ADDR_W:0]             maxc;
  logic [ADDR_W:0]             step;
  logic [PH_W-1:0]             phase;
  logic                        run_pend;

  logic                        hs;
  logic                        coord_ok;
  logic [ADDR_W:0]             max_cnt;
  logic [ADDR_W:0]             tgt_cnt;
  logic                        step_adv;
  logic                        run_last;
  logic [ADDR_W:0]             step_nxt;
  logic                        drive_run;

  assign cmd_ready = (state == IDLE) && !clear_req && !rst;
  assign hs        = cmd_valid && cmd_ready;
  assign coord_ok  = ROW_MASK[cmd_row] && COL_MASK[cmd_col];
  assign step_adv  = (phase == PH_LAST);
  assign run_last  = (maxc == '0) ||
                     (step_adv && (step == maxc - (ADDR_W+1)'(1)));

  // Largest loaded program length and the addressed tile's current count.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    max_cnt = '0;
    tgt_cnt = '0;
    for (int r = 0; r < X; r++) begin
      for (int c = 0; c < Y; c++) begin
        if (cnt[r][c] > max_cnt) max_cnt = cnt[r][c];
        if (cmd_row == ROW_W'(r) && cmd_col == COL_W'(c)) tgt_cnt = cnt[r][c];
      end
    end
  end

  // Which run step the array shows next cycle, and whether it shows one at all.
  always_comb begin
    step_nxt  = '0;
    drive_run = 1'b0;
    if (state == IDLE) begin
      drive_run = !clear_req && (run_req || run_pend) && !hs;
    end else if (state == RUN) begin
      drive_run = !run_last;
      step_nxt  = step_adv ? step + (ADDR_W+1)'(1) : step;
    end
  end

  // Control FSM, per-tile counts and all registered array outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      // NOTE: cnt is program-length state that the array behaviour depends on, so it is reset explicitly.
      state         <= IDLE;
      cnt           <= '0;
      maxc          <= '0;
      step          <= '0;
      phase         <= '0;
      run_pend      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= '0;
      start_instr_b <= '1;
      read_or_write <= '0;
      addr_count    <= '0;
      instr_in      <= '0;
    end else begin
      // NOTE: non-blocking only; idle defaults come first and later overrides win.
      start_instr_b <= '1;
      read_or_write <= '0;
      addr_count    <= '0;
      instr_in      <= '0;
      done          <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear_req) begin
            cnt      <= '0;
            err      <= '0;
            run_pend <= 1'b0;
          end else begin
            if (hs) begin
              if (!coord_ok) begin
                err[1] <= 1'b1;
              end else if (tgt_cnt == DEPTH) begin
                err[0] <= 1'b1;
              end else begin
                for (int r = 0; r < X; r++) begin
                  for (int c = 0; c < Y; c++) begin
                    if (cmd_row == ROW_W'(r) && cmd_col == COL_W'(c)) begin
                      start_instr_b[r][c] <= 1'b0;
                      read_or_write[r][c] <= 1'b1;
                      addr_count[r][c]    <= tgt_cnt[ADDR_W-1:0];
                      instr_in[r][c]      <= cmd_instr;
                      cnt[r][c]           <= tgt_cnt + (ADDR_W+1)'(1);
                    end
                  end
                end
              end
            end
            // A run requested alongside a load waits one cycle so the write strobe completes first.
            if (run_req || run_pend) begin
              if (hs) begin
                run_pend <= 1'b1;
              end else begin
                run_pend <= 1'b0;
                state    <= RUN;
                busy     <= 1'b1;
                maxc     <= max_cnt;
                step     <= '0;
                phase    <= '0;
              end
            end
          end
        end
        RUN: begin
          if (run_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            phase <= step_adv ? '0 : phase + PH_W'(1);
            step  <= step_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Execute strobes for the step shown next cycle, on tiles whose program reaches it.
      if (drive_run) begin
        for (int r = 0; r < X; r++) begin
          for (int c = 0; c < Y; c++) begin
            if (step_nxt < cnt[r][c]) begin
              start_instr_b[r][c] <= 1'b0;
              addr_count[r][c]    <= step_nxt[ADDR_W-1:0];
            end
          end
        end
      end
    end
  end

endmodule
